stall_ctrl: RTL
===============

# stall_ctrl

Pipeline stall sequencer for the RV32I core. Collects stall requests from the data cache, the instruction cache and the monitor run/halt control, and generates the stall, 1-shot and delayed-stall strobes. The execution stage uses these strobes to capture roll-back state and to replay into the memory-access stage. It also owns the pipeline-restart pulse, a cache-wait watchdog and a stalled-cycle performance counter.

## Interface
- TIMEOUT, default 1023: number of wait cycles in a cache-wait state before the watchdog fires. Range 2..65535.
- clk  input  1  core clock
- rst_n  input  1  asynchronous, active-low reset
- dc_stall_req  input  1  level; data-cache miss pending
- dc_stall_fin  input  1  1-cycle pulse; data-cache miss complete
- ic_stall_req  input  1  level; instruction-cache miss pending
- ic_stall_fin  input  1  1-cycle pulse; instruction-cache miss complete
- cpu_run  input  1  monitor level; 0 requests halt
- cpu_start  input  1  monitor 1-cycle pulse; leave halt
- cnt_clr  input  1  clears stall_cycles and wdt_err
- stall  output  1  freeze IF..MA pipeline registers
- stall_1shot  output  1  first cycle of a stall period
- stall_dly  output  1  stall delayed 1 cycle
- stall_dly2  output  1  stall delayed 2 cycles
- rst_pipe  output  1  1-cycle pipeline flush pulse
- stall_state  output  3  current FSM state encoding
- wdt_err  output  1  sticky watchdog-timeout flag
- stall_cycles  output  32  saturating count of stalled cycles outside HALT

## Operation
- FSM states and encodings:
  - HALT=0 (reset state)
  - RESUME=1
  - RUN=2
  - DC_WAIT=3
  - IC_WAIT=4
- RUN transitions, in priority order:
  - dc_stall_req goes to DC_WAIT.
  - Otherwise ic_stall_req goes to IC_WAIT.
  - Otherwise ~cpu_run goes to HALT.
  - Otherwise stay in RUN.
  - dc beats ic because the memory transaction is already issued. Halt never preempts a new cache request.
- DC_WAIT transitions:
  - dc_stall_fin goes to RUN.
  - Otherwise, wdt_cnt reaching TIMEOUT sets wdt_err and goes to RESUME.
  - fin wins when fin and timeout occur in the same cycle.
- IC_WAIT: identical to DC_WAIT, using ic_stall_fin.
- HALT: cpu_start goes to RESUME. cpu_run is ignored while in HALT.
- RESUME: asserts rst_pipe for exactly its one cycle, then goes to RUN unconditionally.
- stall = (state != RUN) | (state == RUN & (dc_stall_req | ic_stall_req | ~cpu_run)). This is Mealy and combinational, so the requester sees the freeze in its request cycle.
- stall_1shot = stall & ~stall_dly.
- stall_dly and stall_dly2 form a 2-stage register chain fed by stall.
- Watchdog counter wdt_cnt (16 bit):
  - Cleared on every entry to DC_WAIT or IC_WAIT.
  - Increments each cycle the FSM is in a wait state.
  - A fin pulse arriving outside the matching wait state is ignored.
- stall_cycles:
  - Increments when stall & (state != HALT).
  - Saturates at 0xFFFFFFFF.
  - cnt_clr has priority over increment.
- wdt_err: set-dominant when a timeout and cnt_clr occur in the same cycle.

## Timing
- Reset values:
  - state = HALT, so stall = 1 and stall_1shot = 1 in the first cycle after reset.
  - stall_dly = 0, stall_dly2 = 0, rst_pipe = 0, wdt_err = 0, stall_cycles = 0, wdt_cnt = 0.
- Asynchronous reset mid-wait: FSM forced to HALT and the cache wait is abandoned. The cache is reset by the same rst_n.
- Data-cache miss: request raised in cycle N.
  - stall = 1 in N and stall_1shot = 1 in N.
  - DC_WAIT from N+1.
  - fin in cycle M keeps stall = 1 in M; stall = 0 in M+1 if no new request.
  - stall_dly falls in M+2 and stall_dly2 falls in M+3.
- Back-to-back: a new dc_stall_req in M+1 produces stall = 1 again, with stall_1shot = 0 because stall_dly = 1.
- Halt exit: cpu_start in cycle N gives RESUME in N+1 (rst_pipe = 1, stall = 1), then RUN in N+2.
- stall_state is registered and equals the FSM state.

## Structure
- Shared package or include file: state encodings (ST_HALT..ST_IC_WAIT) and the default TIMEOUT constant.
- Single module; no sub-module required. The watchdog and perf counter are inline always blocks.

## Test plan
- Reset then cpu_start at cycle 3: stall = 1 for cycles 0..4, rst_pipe = 1 only in cycle 4, stall = 0 from cycle 5, stall_state = 2.
- dc_stall_req high in cycles 10..15 with dc_stall_fin in cycle 15:
  - stall = 1 in 10..15, stall_1shot = 1 only in 10.
  - stall_dly = 1 in 11..16, stall_dly2 = 1 in 12..17.
  - stall_cycles increases by 6.
- dc_stall_req and ic_stall_req both high in the same RUN cycle: DC_WAIT first. After dc fin, with ic still requesting, IC_WAIT next with stall continuously 1 and stall_1shot not re-asserted.
- TIMEOUT=8 with no fin: wdt_err = 1 after 8 wait cycles, one rst_pipe pulse, then RUN. A fin in the same cycle as the timeout instead returns to RUN with wdt_err = 0.
- cpu_run dropped during DC_WAIT: halt entered only after dc_stall_fin, one RUN cycle later. stall_cycles stops counting in HALT. cnt_clr clears the counter to 0.
- rst_n asserted mid DC_WAIT: all outputs return to their reset values immediately, state = HALT.

Source files
------------

// File: rtl/stall_ctrl_pkg.sv
// rtl/stall_ctrl_pkg.sv - state encodings and defaults for the pipeline stall sequencer
package stall_ctrl_pkg;

  typedef enum logic [2:0] {
    ST_HALT    = 3'd0,
    ST_RESUME  = 3'd1,
    ST_RUN     = 3'd2,
    ST_DC_WAIT = 3'd3,
    ST_IC_WAIT = 3'd4
  } state_e;

  localparam int unsigned TIMEOUT_DEFAULT = 1023;
  localparam logic [31:0] STALL_CYCLES_MAX = 32'hFFFF_FFFF;

endpackage

// File: rtl/stall_ctrl.sv
// rtl/stall_ctrl.sv - pipeline stall sequencer with restart pulse, cache-wait watchdog and stall counter
module stall_ctrl
  import stall_ctrl_pkg::*;
#(
  parameter int unsigned TIMEOUT = TIMEOUT_DEFAULT
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        dc_stall_req,
  input  logic        dc_stall_fin,
  input  logic        ic_stall_req,
  input  logic        ic_stall_fin,
  input  logic        cpu_run,
  input  logic        cpu_start,
  input  logic        cnt_clr,
  output logic        stall,
  output logic        stall_1shot,
  output logic        stall_dly,
  output logic        stall_dly2,
  output logic        rst_pipe,
  output logic [2:0]  stall_state,
  output logic        wdt_err,
  output logic [31:0] stall_cycles
);

  // The watchdog fires in the wait cycle whose count value is TIMEOUT-1,
  // i.e. after TIMEOUT cycles spent in the wait state.
  localparam logic [15:0] WDT_LAST = 16'(TIMEOUT - 1);

  state_e      state_q, state_d;
  logic        stall_dly_q, stall_dly_d;
  logic        stall_dly2_q, stall_dly2_d;
  logic        rst_pipe_q, rst_pipe_d;
  logic [15:0] wdt_cnt_q, wdt_cnt_d;
  logic        wdt_err_q, wdt_err_d;
  logic [31:0] stall_cycles_q, stall_cycles_d;
  logic        timeout;
  logic        in_wait;
  logic        stall_c;

  // Next-state logic; a cache completion beats a simultaneous watchdog timeout
  always_comb begin
    state_d = state_q;
    timeout = 1'b0;
    unique case (state_q)
      ST_HALT: begin
        if (cpu_start) state_d = ST_RESUME;
      end
      ST_RESUME: begin
        state_d = ST_RUN;
      end
      ST_RUN: begin
        if (dc_stall_req)      state_d = ST_DC_WAIT;
        else if (ic_stall_req) state_d = ST_IC_WAIT;
        else if (!cpu_run)     state_d = ST_HALT;
      end
      ST_DC_WAIT: begin
        if (dc_stall_fin) begin
          state_d = ST_RUN;
        end else if (wdt_cnt_q == WDT_LAST) begin
          timeout = 1'b1;
          state_d = ST_RESUME;
        end
      end
      ST_IC_WAIT: begin
        if (ic_stall_fin) begin
          state_d = ST_RUN;
        end else if (wdt_cnt_q == WDT_LAST) begin
          timeout = 1'b1;
          state_d = ST_RESUME;
        end
      end
      default: state_d = ST_HALT;
    endcase
  end

  // Mealy stall so a requester sees the freeze in its own request cycle
  always_comb begin
    stall_c = 1'b1;
    if (state_q == ST_RUN) stall_c = dc_stall_req | ic_stall_req | ~cpu_run;
  end

  // Delay chain, restart pulse, watchdog counter and sticky error
  always_comb begin
    in_wait      = (state_q == ST_DC_WAIT) || (state_q == ST_IC_WAIT);
    stall_dly_d  = stall_c;
    stall_dly2_d = stall_dly_q;
    rst_pipe_d   = (state_d == ST_RESUME);
    wdt_cnt_d    = in_wait ? wdt_cnt_q + 16'd1 : 16'd0;
    wdt_err_d    = wdt_err_q;
    if (timeout)      wdt_err_d = 1'b1;
    else if (cnt_clr) wdt_err_d = 1'b0;
  end

  // Saturating count of stalled cycles, halted cycles excluded
  always_comb begin
    stall_cycles_d = stall_cycles_q;
    if (cnt_clr) begin
      stall_cycles_d = 32'd0;
    end else if (stall_c && (state_q != ST_HALT) && (stall_cycles_q != STALL_CYCLES_MAX)) begin
      stall_cycles_d = stall_cycles_q + 32'd1;
    end
  end

  // State and registered outputs; reset abandons any cache wait
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q        <= ST_HALT;
      stall_dly_q    <= 1'b0;
      stall_dly2_q   <= 1'b0;
      rst_pipe_q     <= 1'b0;
      wdt_cnt_q      <= 16'd0;
      wdt_err_q      <= 1'b0;
      stall_cycles_q <= 32'd0;
    end else begin
      state_q        <= state_d;
      stall_dly_q    <= stall_dly_d;
      stall_dly2_q   <= stall_dly2_d;
      rst_pipe_q     <= rst_pipe_d;
      wdt_cnt_q      <= wdt_cnt_d;
      wdt_err_q      <= wdt_err_d;
      stall_cycles_q <= stall_cycles_d;
    end
  end

  assign stall        = stall_c;
  assign stall_1shot  = stall_c & ~stall_dly_q;
  assign stall_dly    = stall_dly_q;
  assign stall_dly2   = stall_dly2_q;
  assign rst_pipe     = rst_pipe_q;
  assign stall_state  = state_q;
  assign wdt_err      = wdt_err_q;
  assign stall_cycles = stall_cycles_q;

endmodule
